// File: rtl/hazard3_pmp_programmer_pkg.sv
// Shared definitions for the PMP region programmer.
// Contents: PMP CSR base addresses, pmpcfg A-field encodings,
// response error codes, the programmer FSM state encoding, and a
// helper that assembles a pmpcfg byte.
package hazard3_pmp_programmer_pkg;

  localparam logic [11:0] PMPCFG0  = 12'h3A0;
  localparam logic [11:0] PMPADDR0 = 12'h3B0;

  // TOR is listed for completeness. The programmer never generates it.
  typedef enum logic [1:0] {
    A_OFF   = 2'b00,
    A_TOR   = 2'b01,
    A_NA4   = 2'b10,
    A_NAPOT = 2'b11
  } pmp_a_e;

  typedef enum logic [2:0] {
    ERR_OK     = 3'd0,
    ERR_INDEX  = 3'd1,
    ERR_ALIGN  = 3'd2,
    ERR_SIZE   = 3'd3,
    ERR_LOCKED = 3'd4,
    ERR_WARL   = 3'd5
  } resp_err_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CFG  = 3'd1,
    ST_WR_OFF  = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_CFG  = 3'd4,
    ST_RB_CFG  = 3'd5,
    ST_RB_ADDR = 3'd6,
    ST_RESP    = 3'd7
  } state_e;

  // pmpcfg byte layout: {L, 2'b00, A[1:0], R, W, X}
  function automatic logic [7:0] make_cfg_byte(logic lock, pmp_a_e a, logic [2:0] rwx);
    return {lock, 2'b00, a, rwx};
  endfunction

endpackage

// File: rtl/hazard3_pmp_programmer_if.sv
// Bus bundle for the PMP programmer.
// Request channel: req_valid/req_ready plus the region fields.
// Response channel: resp_valid/resp_ready plus resp_err.
// Config channel: cfg_addr/cfg_wen/cfg_wdata out, cfg_rdata in (combinational).
// Handshake rule for both req and resp: a transfer happens on a rising clk
// edge where valid && ready. The producer holds valid and its payload
// stable until that edge. ready may be asserted independently of valid.
// Modports: slave = the programmer; master = requester plus PMP CSR block.
interface hazard3_pmp_programmer_if
  import hazard3_pmp_programmer_pkg::*;
#(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_index;
  logic [W_ADDR-1:0] req_base;
  logic [5:0]        req_size_log2;
  logic [2:0]        req_rwx;
  logic              req_lock;
  logic              resp_valid;
  logic              resp_ready;
  resp_err_e         resp_err;
  logic [11:0]       cfg_addr;
  logic              cfg_wen;
  logic [W_DATA-1:0] cfg_wdata;
  logic [W_DATA-1:0] cfg_rdata;

  modport slave (
    input  req_valid, req_index, req_base, req_size_log2, req_rwx, req_lock,
    input  resp_ready, cfg_rdata,
    output req_ready, resp_valid, resp_err, cfg_addr, cfg_wen, cfg_wdata
  );

  modport master (
    output req_valid, req_index, req_base, req_size_log2, req_rwx, req_lock,
    output resp_ready, cfg_rdata,
    input  req_ready, resp_valid, resp_err, cfg_addr, cfg_wen, cfg_wdata
  );
endinterface

// File: rtl/hazard3_pmp_napot_encode.sv
// Combinational region encoder.
// Inputs : size_log2_i (k), base_i (byte address).
// Outputs: pmpaddr_o (pmpaddr register value), a_o (A field),
//          size_ok_o (k legal for this grain), align_ok_o (base aligned to 2^k).
// k=0 -> OFF, k=2 -> NA4, k=3..32 -> NAPOT.
module hazard3_pmp_napot_encode
  import hazard3_pmp_programmer_pkg::*;
#(
  parameter int PMP_GRAIN = 0,
  parameter int W_ADDR    = 32
) (
  input  logic [5:0]        size_log2_i,
  input  logic [W_ADDR-1:0] base_i,
  output logic [31:0]       pmpaddr_o,
  output pmp_a_e            a_o,
  output logic              size_ok_o,
  output logic              align_ok_o
);

  logic [31:0] word_addr;
  logic [31:0] napot_clr;
  logic [31:0] napot_set;
  logic [63:0] align_mask;

  always_comb begin
    word_addr  = {2'b00, base_i[31:2]};
    // Low k-2 word-address bits are cleared, then the low k-3 are set.
    // For k<3 the shift amounts wrap, but those results are overridden below.
    napot_clr  = (32'd1 << (size_log2_i - 6'd2)) - 32'd1;
    napot_set  = (32'd1 << (size_log2_i - 6'd3)) - 32'd1;
    // 64-bit mask so that k=32 still yields a full 32-bit alignment mask.
    align_mask = (64'd1 << size_log2_i) - 64'd1;
    align_ok_o = ((64'(base_i) & align_mask) == 64'd0);
    size_ok_o  = (size_log2_i == 6'd0) ||
                 ((size_log2_i >= 6'd2) && (size_log2_i <= 6'd32) &&
                  (int'(size_log2_i) >= PMP_GRAIN + 2));
    a_o        = A_NAPOT;
    pmpaddr_o  = (word_addr & ~napot_clr) | napot_set;
    if (size_log2_i == 6'd0) begin
      a_o       = A_OFF;
      pmpaddr_o = word_addr;
    end else if (size_log2_i == 6'd2) begin
      a_o       = A_NA4;
      pmpaddr_o = word_addr;
    end
  end

endmodule

// File: rtl/hazard3_pmp_programmer.sv
// PMP region programmer.
// Accepts a region request on bus (slave modport), validates it, then runs
// read cfg -> write cfg lane OFF -> write pmpaddr -> write final cfg ->
// read back cfg -> read back pmpaddr -> respond.
// Ports: clk, rst_n (async active-low), bus (request/response/config channels),
//        dbg_state_o (current FSM state for observation).
module hazard3_pmp_programmer
  import hazard3_pmp_programmer_pkg::*;
#(
  parameter int PMP_REGIONS = 4,
  parameter int PMP_GRAIN   = 0,
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hazard3_pmp_programmer_if.slave  bus,
  output state_e                   dbg_state_o
);

  // With G>=2 the low G-1 pmpaddr bits read back as ones/WARL, so they are
  // excluded from the readback compare.
  localparam int GP = (PMP_GRAIN > 0) ? PMP_GRAIN - 1 : 0;
  localparam logic [W_DATA-1:0] RB_MASK =
    W_DATA'(((64'd1 << 30) - 64'd1) & ~((64'd1 << GP) - 64'd1));

  state_e            state_q, state_d;
  logic [3:0]        index_q, index_d;
  logic [5:0]        k_q, k_d;
  logic [W_DATA-1:0] addr_q, addr_d;
  logic [7:0]        byte_q, byte_d;
  logic [W_DATA-1:0] shadow_q, shadow_d;
  resp_err_e         err_q, err_d;

  logic [31:0]       enc_addr;
  pmp_a_e            enc_a;
  logic              enc_size_ok;
  logic              enc_align_ok;

  hazard3_pmp_napot_encode #(
    .PMP_GRAIN (PMP_GRAIN),
    .W_ADDR    (W_ADDR)
  ) u_encode (
    .size_log2_i (bus.req_size_log2),
    .base_i      (bus.req_base),
    .pmpaddr_o   (enc_addr),
    .a_o         (enc_a),
    .size_ok_o   (enc_size_ok),
    .align_ok_o  (enc_align_ok)
  );

  logic [4:0]        lane_sh;
  logic [11:0]       cfg_word_addr;
  logic [11:0]       pmpaddr_addr;
  logic [7:0]        rd_lane;
  logic [W_DATA-1:0] lane_mask;

  assign lane_sh       = {index_q[1:0], 3'b000};
  assign cfg_word_addr = PMPCFG0 + {10'd0, index_q[3:2]};
  assign pmpaddr_addr  = PMPADDR0 + {8'd0, index_q};
  assign rd_lane       = bus.cfg_rdata[lane_sh +: 8];
  assign lane_mask     = W_DATA'(8'hFF) << lane_sh;

  assign bus.resp_err  = err_q;
  assign dbg_state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      byte_q   <= '0;
      shadow_q <= '0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      byte_q   <= byte_d;
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    k_d           = k_q;
    addr_d        = addr_q;
    byte_d        = byte_q;
    shadow_d      = shadow_q;
    err_d         = err_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.cfg_addr   = 12'h000;
    bus.cfg_wen    = 1'b0;
    bus.cfg_wdata  = '0;

    unique case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          index_d = bus.req_index;
          k_d     = bus.req_size_log2;
          addr_d  = W_DATA'(enc_addr);
          byte_d  = make_cfg_byte(bus.req_lock, enc_a, bus.req_rwx);
          err_d   = ERR_OK;
          state_d = ST_RD_CFG;
          // Pre-checks in priority order; a failure skips all cfg traffic.
          if (int'(bus.req_index) >= PMP_REGIONS) begin
            err_d   = ERR_INDEX;
            state_d = ST_RESP;
          end else if (!enc_size_ok) begin
            err_d   = ERR_SIZE;
            state_d = ST_RESP;
          end else if (!enc_align_ok) begin
            err_d   = ERR_ALIGN;
            state_d = ST_RESP;
          end
        end
      end
      ST_RD_CFG: begin
        bus.cfg_addr = cfg_word_addr;
        shadow_d     = bus.cfg_rdata;
        if (rd_lane[7]) begin
          err_d   = ERR_LOCKED;
          state_d = ST_RESP;
        end else begin
          state_d = ST_WR_OFF;
        end
      end
      ST_WR_OFF: begin
        // Disable the region before its address changes.
        bus.cfg_addr  = cfg_word_addr;
        bus.cfg_wen   = 1'b1;
        bus.cfg_wdata = shadow_q & ~lane_mask;
        state_d       = (k_q == 6'd0) ? ST_WR_CFG : ST_WR_ADDR;
      end
      ST_WR_ADDR: begin
        bus.cfg_addr  = pmpaddr_addr;
        bus.cfg_wen   = 1'b1;
        bus.cfg_wdata = addr_q;
        state_d       = ST_WR_CFG;
      end
      ST_WR_CFG: begin
        bus.cfg_addr  = cfg_word_addr;
        bus.cfg_wen   = 1'b1;
        bus.cfg_wdata = (shadow_q & ~lane_mask) | (W_DATA'(byte_q) << lane_sh);
        state_d       = ST_RB_CFG;
      end
      ST_RB_CFG: begin
        bus.cfg_addr = cfg_word_addr;
        if (rd_lane != byte_q) begin
          err_d   = ERR_WARL;
          state_d = ST_RESP;
        end else begin
          state_d = (k_q == 6'd0) ? ST_RESP : ST_RB_ADDR;
        end
      end
      ST_RB_ADDR: begin
        bus.cfg_addr = pmpaddr_addr;
        if (((bus.cfg_rdata ^ addr_q) & RB_MASK) != '0) begin
          err_d = ERR_WARL;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hazard3_pmp_programmer.sv
// Directed bench for hazard3_pmp_programmer with a behavioural PMP CSR model.
module tb_hazard3_pmp_programmer;
  import hazard3_pmp_programmer_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard3_pmp_programmer_if #(.W_ADDR(32), .W_DATA(32)) bus ();
  hazard3_pmp_programmer_if #(.W_ADDR(32), .W_DATA(32)) bus_g1 ();
  state_e dbg_state;
  state_e dbg_state_g1;

  hazard3_pmp_programmer #(
    .PMP_REGIONS (8), .PMP_GRAIN (0), .W_ADDR (32), .W_DATA (32)
  ) dut (
    .clk (clk), .rst_n (rst_n), .bus (bus), .dbg_state_o (dbg_state)
  );

  hazard3_pmp_programmer #(
    .PMP_REGIONS (8), .PMP_GRAIN (1), .W_ADDR (32), .W_DATA (32)
  ) dut_g1 (
    .clk (clk), .rst_n (rst_n), .bus (bus_g1), .dbg_state_o (dbg_state_g1)
  );

  // ---------------- PMP CSR model ----------------
  logic [31:0] cfg_mem  [4]  = '{default: 32'd0};
  logic [31:0] addr_mem [16] = '{default: 32'd0};
  logic        hw_cfg2  = 1'b0;   // entry 2 cfg lane reads as zero
  logic        hw_addr2 = 1'b0;   // pmpaddr2 reads as zero
  logic        load_en  = 1'b0;
  logic [1:0]  load_idx = 2'd0;
  logic [31:0] load_val = 32'd0;

  always_comb begin
    bus.cfg_rdata = 32'd0;
    if (bus.cfg_addr[11:2] == 10'h0E8) begin
      bus.cfg_rdata = cfg_mem[bus.cfg_addr[1:0]];
      if (hw_cfg2 && bus.cfg_addr[1:0] == 2'd0) bus.cfg_rdata[23:16] = 8'h00;
    end else if (bus.cfg_addr[11:4] == 8'h3B) begin
      bus.cfg_rdata = addr_mem[bus.cfg_addr[3:0]];
      if (hw_addr2 && bus.cfg_addr[3:0] == 4'd2) bus.cfg_rdata = 32'd0;
    end
  end

  always @(posedge clk) begin
    if (load_en) cfg_mem[load_idx] = load_val;
    else if (bus.cfg_wen) begin
      if (bus.cfg_addr[11:2] == 10'h0E8) cfg_mem[bus.cfg_addr[1:0]] = bus.cfg_wdata;
      else if (bus.cfg_addr[11:4] == 8'h3B) addr_mem[bus.cfg_addr[3:0]] = bus.cfg_wdata;
    end
  end

  // ---------------- write monitor ----------------
  logic [43:0] obs_log [64];
  int          obs_cnt    = 0;
  int          g1_wen_cnt = 0;
  always @(negedge clk) begin
    if (bus.cfg_wen && obs_cnt < 64) begin
      obs_log[obs_cnt] = {bus.cfg_addr, bus.cfg_wdata};
      obs_cnt++;
    end
    if (bus_g1.cfg_wen) g1_wen_cnt++;
  end

  // ---------------- scoreboard ----------------
  logic [43:0] exp_q[$];
  int obs_rd = 0;
  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [11:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string tag);
    logic [43:0] e;
    check({tag, "_nwr"}, 64'(obs_cnt - obs_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_cnt) begin
        check({tag, "_wr"}, 64'(obs_log[obs_rd]), 64'(e));
        obs_rd++;
      end
    end
    obs_rd = obs_cnt;
  endtask

  // ---------------- drivers ----------------
  task automatic load_cfg(input logic [1:0] i, input logic [31:0] v);
    @(negedge clk);
    load_en = 1'b1; load_idx = i; load_val = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send(input logic [3:0] idx, input logic [31:0] base, input logic [5:0] k,
                      input logic [2:0] rwx, input logic lock,
                      output int wait_cyc, output int lat, output logic [2:0] err,
                      output logic held);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_index = idx; bus.req_base = base;
    bus.req_size_log2 = k; bus.req_rwx = rwx; bus.req_lock = lock;
    wait_cyc = 0;
    while (bus.req_ready !== 1'b1 && wait_cyc < 20) begin
      @(negedge clk); wait_cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    err = bus.resp_err;
    @(negedge clk);
    held = bus.resp_valid;
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int          wc, lat;
  logic [2:0]  err;
  logic        held;

  initial begin
    bus.req_valid = 1'b0; bus.req_index = '0; bus.req_base = '0;
    bus.req_size_log2 = '0; bus.req_rwx = '0; bus.req_lock = 1'b0; bus.resp_ready = 1'b0;
    bus_g1.req_valid = 1'b0; bus_g1.req_index = '0; bus_g1.req_base = '0;
    bus_g1.req_size_log2 = '0; bus_g1.req_rwx = '0; bus_g1.req_lock = 1'b0;
    bus_g1.resp_ready = 1'b0; bus_g1.cfg_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_cfg_wen", bus.cfg_wen, 0);
    check("rst_cfg_addr", bus.cfg_addr, 0);
    check("rst_cfg_wdata", bus.cfg_wdata, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst_n = 1'b1;

    load_cfg(2'd0, 32'hAA00009F);
    load_cfg(2'd1, 32'h11223344);

    // NAPOT 4 KiB region at entry 1, other lanes preserved
    expect_wr(12'h3A0, 32'hAA00009F);
    expect_wr(12'h3B1, 32'h080005FF);
    expect_wr(12'h3A0, 32'hAA001D9F);
    send(4'd1, 32'h20001000, 6'd12, 3'b101, 1'b0, wc, lat, err, held);
    check("t1_err", err, ERR_OK);
    check("t1_lat", lat, 7);
    check("t1_resp_held", held, 1);
    check_writes("t1");
    check("t1_cfg0", cfg_mem[0], 32'hAA001D9F);

    // Entry 0 is locked; back-to-back accept
    send(4'd0, 32'h0, 6'd12, 3'b111, 1'b0, wc, lat, err, held);
    check("lock_wait", wc, 0);
    check("lock_err", err, ERR_LOCKED);
    check("lock_lat", lat, 2);
    check_writes("lock");

    // Misaligned base
    send(4'd1, 32'h20000800, 6'd12, 3'b101, 1'b0, wc, lat, err, held);
    check("align_err", err, ERR_ALIGN);
    check("align_lat", lat, 1);
    check_writes("align");

    // NA4 at entry 5 (cfg word 1, lane 1)
    expect_wr(12'h3A1, 32'h11220044);
    expect_wr(12'h3B5, 32'h00000004);
    expect_wr(12'h3A1, 32'h11221444);
    send(4'd5, 32'h10, 6'd2, 3'b100, 1'b0, wc, lat, err, held);
    check("na4_err", err, ERR_OK);
    check("na4_lat", lat, 7);
    check_writes("na4");

    // Same NA4 request on a G=1 instance is a size error
    @(negedge clk);
    bus_g1.req_valid = 1'b1; bus_g1.req_index = 4'd5; bus_g1.req_base = 32'h10;
    bus_g1.req_size_log2 = 6'd2; bus_g1.req_rwx = 3'b100;
    check("g1_ready", bus_g1.req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus_g1.req_valid = 1'b0;
    check("g1_resp_valid", bus_g1.resp_valid, 1);
    check("g1_err", bus_g1.resp_err, ERR_SIZE);
    bus_g1.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus_g1.resp_ready = 1'b0;
    @(negedge clk);
    check("g1_no_wen", g1_wen_cnt, 0);
    check("g1_state", dbg_state_g1, ST_IDLE);

    // Whole 4 GiB NAPOT at entry 2
    expect_wr(12'h3A0, 32'hAA001D9F);
    expect_wr(12'h3B2, 32'h1FFFFFFF);
    expect_wr(12'h3A0, 32'hAA1B1D9F);
    send(4'd2, 32'h0, 6'd32, 3'b011, 1'b0, wc, lat, err, held);
    check("k32_err", err, ERR_OK);
    check("k32_lat", lat, 7);
    check_writes("k32");

    // Entry 2 cfg hardwired -> readback mismatch on cfg
    hw_cfg2 = 1'b1;
    expect_wr(12'h3A0, 32'hAA001D9F);
    expect_wr(12'h3B2, 32'h1FFFFFFF);
    expect_wr(12'h3A0, 32'hAA1B1D9F);
    send(4'd2, 32'h0, 6'd32, 3'b011, 1'b0, wc, lat, err, held);
    check("hwcfg_err", err, ERR_WARL);
    check("hwcfg_lat", lat, 6);
    check_writes("hwcfg");
    hw_cfg2 = 1'b0;

    // Entry 2 pmpaddr hardwired -> readback mismatch on address
    hw_addr2 = 1'b1;
    expect_wr(12'h3A0, 32'hAA001D9F);
    expect_wr(12'h3B2, 32'h1FFFFFFF);
    expect_wr(12'h3A0, 32'hAA1B1D9F);
    send(4'd2, 32'h0, 6'd32, 3'b011, 1'b0, wc, lat, err, held);
    check("hwaddr_err", err, ERR_WARL);
    check("hwaddr_lat", lat, 7);
    check_writes("hwaddr");
    hw_addr2 = 1'b0;

    // Pre-check boundaries and priority
    send(4'd8, 32'h0, 6'd12, 3'b000, 1'b0, wc, lat, err, held);
    check("idx8_err", err, ERR_INDEX);
    check("idx8_lat", lat, 1);
    send(4'd8, 32'h3, 6'd1, 3'b000, 1'b0, wc, lat, err, held);
    check("idx_over_size_err", err, ERR_INDEX);
    send(4'd7, 32'h2, 6'd1, 3'b000, 1'b0, wc, lat, err, held);
    check("k1_err", err, ERR_SIZE);
    send(4'd3, 32'h0, 6'd33, 3'b000, 1'b0, wc, lat, err, held);
    check("k33_err", err, ERR_SIZE);
    check_writes("prechk");

    // k=0 turns entry 7 off with L and X set, no pmpaddr traffic
    expect_wr(12'h3A1, 32'h00221444);
    expect_wr(12'h3A1, 32'h81221444);
    send(4'd7, 32'h123, 6'd0, 3'b001, 1'b1, wc, lat, err, held);
    check("off_err", err, ERR_OK);
    check("off_lat", lat, 5);
    check_writes("off");

    // Reset while in WR_ADDR
    expect_wr(12'h3A1, 32'h81001444);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_index = 4'd6; bus.req_base = 32'h1000;
    bus.req_size_log2 = 6'd12; bus.req_rwx = 3'b111; bus.req_lock = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_wr_addr_wen", bus.cfg_wen, 1);
    check("mid_wr_addr_addr", bus.cfg_addr, 12'h3B6);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wen", bus.cfg_wen, 0);
    @(negedge clk);
    check("mid_rst_ready", bus.req_ready, 1);
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_writes("midrst");
    check("midrst_addr6", addr_mem[6], 32'h0);

    expect_wr(12'h3A1, 32'h81001444);
    expect_wr(12'h3B6, 32'h000005FF);
    expect_wr(12'h3A1, 32'h811F1444);
    send(4'd6, 32'h1000, 6'd12, 3'b111, 1'b0, wc, lat, err, held);
    check("after_rst_err", err, ERR_OK);
    check("after_rst_lat", lat, 7);
    check_writes("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hazard3_pmp_programmer.md
Name: hazard3_pmp_programmer

Overview:
Hardware initiator for the PMP config interface. It accepts a high-level region request (index, base, log2 size, permissions, lock), encodes it into NA4/NAPOT pmpaddr form and a pmpcfg byte, and applies it with a safe read-modify-write sequence. It then reads both registers back to confirm the WARL result. It sits beside the CSR block and lets a debug/boot sequencer or accelerator program PMP regions without software CSR instructions.

Parameters:
PMP_REGIONS, 4, number of implemented PMP entries (1..16)
PMP_GRAIN, 0, PMP granularity G; minimum region is 2^(G+2) bytes
W_ADDR, 32, address width
W_DATA, 32, cfg data width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready
req_index  input  4  PMP entry index
req_base  input  W_ADDR  region base byte address
req_size_log2  input  6  region size log2 bytes; 0 = turn entry OFF; else 2..32
req_rwx  input  3  {R,W,X}
req_lock  input  1  set L bit
resp_valid  output  1  result valid, held until resp_ready
resp_ready  input  1  result consumed
resp_err  output  3  0 OK, 1 INDEX, 2 ALIGN, 3 SIZE, 4 LOCKED, 5 WARL
cfg_addr  output  12  CSR address to PMP block
cfg_wen  output  1  write strobe, one cycle per write
cfg_wdata  output  W_DATA  write data
cfg_rdata  input  W_DATA  combinational read data for current cfg_addr

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_err=0, cfg_wen=0, cfg_addr=0, cfg_wdata=0, state IDLE.
- CSR addresses: PMPCFG0=0x3A0, PMPADDR0=0x3B0.
- For entry i: cfg word is PMPCFG0+i/4 and cfg byte lane is i%4. Address register is PMPADDR0+i.
- cfg byte layout: {L,2'b00,A[1:0],R,W,X}. A encoding: OFF=00, NA4=10, NAPOT=11. TOR is never generated.
- Address encoding, with k=size_log2:
  - k=2 -> A=NA4, pmpaddr=base[31:2].
  - k in 3..32 -> A=NAPOT, pmpaddr=(base[31:2] & ~((1<<(k-2))-1)) | ((1<<(k-3))-1).
  - k=32 -> pmpaddr=0x1FFFFFFF.
  - k=0 -> A=OFF, pmpaddr write skipped, R/W/X/L written as given.
- Pre-checks run in the accept cycle and generate no cfg traffic. Checks are in priority order:
  - index>=PMP_REGIONS -> INDEX.
  - k=1, k>32, or (k!=0 and k<PMP_GRAIN+2) -> SIZE. This covers NA4 when G>0.
  - base[k-1:0]!=0 -> ALIGN.
- A failed pre-check goes straight to RESP on the next cycle.
- FSM, one cycle per state:
  - IDLE: accept request, latch fields.
  - RD_CFG: drive cfg word address, capture cfg_rdata into shadow. If the target lane L=1 -> RESP with LOCKED.
  - WR_OFF: write shadow with target lane set to 0x00 (region disabled during update).
  - WR_ADDR: write pmpaddr (skipped when k=0).
  - WR_CFG: write shadow with target lane set to final byte. Other lanes are unchanged from the captured value.
  - RB_CFG: compare the target lane of cfg_rdata to the final byte.
  - RB_ADDR: compare cfg_rdata[29:G'] to encoded [29:G'], with G'=max(PMP_GRAIN-1,0). Skipped when k=0.
  - RESP: resp_valid=1 until resp_ready, then IDLE.
- Any readback mismatch -> WARL. Examples: hardwired entry, or unsupported A mapped to OFF.
- req_ready=1 only in IDLE.
- Latency for a full OK request: 7 cycles from accept to resp_valid.
- cfg_wen is asserted only in WR_* states. cfg_addr holds stable across RB_* compares.
- Reset mid-operation: return to IDLE immediately with cfg_wen=0. Writes already issued are not undone.
- Back-to-back: a new request is accepted in the cycle after the resp handshake.

Decomposition:
- Shared package/include: CSR addresses (PMPCFG0, PMPADDR0), A encodings, resp_err codes, FSM state encoding.
- One natural sub-module, hazard3_pmp_napot_encode. It is combinational: {k, base} -> {pmpaddr, A, size_ok, align_ok}.

Test Plan:
- idx=1, base=0x20001000, k=12, rwx=101, lock=0, pmpcfg0 preloaded 0xAA0000_9F -> writes in order:
  - PMPCFG0 with lane1=0x00
  - PMPADDR1=0x080005FF
  - PMPCFG0=0xAA001D9F
  - resp_err=0 at cycle 7.
- Entry 0 locked (pmpcfg0 byte0=0x80), request idx=0 -> resp_err=4, zero cfg_wen pulses.
- base=0x20000800, k=12 -> resp_err=2, no cfg traffic, resp_valid the cycle after accept.
- G=0: idx=5, base=0x10, k=2, rwx=100 -> PMPADDR5=0x4, pmpcfg1 lane1=0x14, OK. G=1: same request -> resp_err=3.
- k=32, base=0, idx=2 -> PMPADDR2=0x1FFFFFFF, lane=0x18|rwx. PMP model with entry 2 hardwired -> resp_err=5.
- Assert rst_n low during WR_ADDR -> cfg_wen=0 and req_ready=1 after reset. A subsequent request completes normally.
